// File: rtl/blockstacker_pkg.sv
// Shared types and screen constants for the blockstacker game datapath.
package blockstacker_pkg;

    typedef enum logic [2:0] {
        INIT_DRAW,
        WAIT_TICK,
        ERASE,
        DRAW,
        STOPPED
    } motion_state_t;

    localparam int SCREEN_X_MIN = 0;
    localparam int SCREEN_X_MAX = 152;
    localparam int BLOCK_W      = 8;

    // Value driven on draw_erase: background erases, block colour draws.
    localparam logic COLOUR_BG    = 1'b1;
    localparam logic COLOUR_BLOCK = 1'b0;

endpackage

// File: rtl/block_motion_ctrl_bounce_step.sv
// Combinational one-step horizontal move with wall bounce, evaluated one bit wider than x.
module bounce_step #(
    parameter int XW    = 8,
    parameter int X_MIN = 0,
    parameter int X_MAX = 152,
    parameter int STEP  = 4
) (
    input  logic [XW-1:0] x,
    input  logic          dir,
    output logic [XW-1:0] next_x,
    output logic          next_dir
);

    logic [XW:0] x_ext;
    logic [XW:0] sum;
    logic [XW:0] lim_lo;

    always_comb begin
        x_ext    = {1'b0, x};
        sum      = x_ext + (XW+1)'(STEP);
        lim_lo   = (XW+1)'(X_MIN + STEP);
        next_x   = x;
        next_dir = dir;
        if (dir) begin
            if (sum >= (XW+1)'(X_MAX)) begin
                next_x   = XW'(X_MAX);
                next_dir = 1'b0;
            end else begin
                next_x = sum[XW-1:0];
            end
        end else begin
            // Compare before subtracting so small x clamps instead of wrapping.
            if (x_ext <= lim_lo) begin
                next_x   = XW'(X_MIN);
                next_dir = 1'b1;
            end else begin
                next_x = x - XW'(STEP);
            end
        end
    end

endmodule

// File: rtl/block_motion_ctrl.sv
// Moves the active block row on frame ticks via erase/draw plot requests.
// Optional BLOCK_MOTION_OVERRUN_CNT_EN adds overrun_cnt/overrun for ticks dropped while busy.
module block_motion_ctrl
    import blockstacker_pkg::*;
#(
    parameter int XW              = 8,
    parameter int X_MIN           = SCREEN_X_MIN,
    parameter int X_MAX           = SCREEN_X_MAX,
    parameter int STEP            = 4,
    parameter int FRAMES_PER_MOVE = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    input  logic          frame_tick,
    input  logic          stop,
    input  logic          draw_ack,
    output logic          draw_req,
    output logic          draw_erase,
    output logic [XW-1:0] draw_x,
    output logic [XW-1:0] x_pos,
    output logic          moving_right,
    output logic          busy,
    output logic          stopped
`ifdef BLOCK_MOTION_OVERRUN_CNT_EN
    ,
    output logic [7:0]    overrun_cnt,
    output logic          overrun
`endif
);

    localparam int CW = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
    localparam logic [CW-1:0] LAST_FRAME = CW'(FRAMES_PER_MOVE - 1);

    motion_state_t state;
    logic [CW-1:0] frame_cnt;
    logic          stop_pend;
    logic [XW-1:0] next_x;
    logic          next_dir;

    bounce_step #(
        .XW    (XW),
        .X_MIN (X_MIN),
        .X_MAX (X_MAX),
        .STEP  (STEP)
    ) u_bounce_step (
        .x        (x_pos),
        .dir      (moving_right),
        .next_x   (next_x),
        .next_dir (next_dir)
    );

    assign busy = (state == INIT_DRAW) || (state == ERASE) || (state == DRAW);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= INIT_DRAW;
            x_pos        <= XW'(X_MIN);
            moving_right <= 1'b1;
            frame_cnt    <= '0;
            stop_pend    <= 1'b0;
            draw_req     <= 1'b0;
            draw_erase   <= COLOUR_BLOCK;
            draw_x       <= XW'(X_MIN);
            stopped      <= 1'b0;
        end else begin
            case (state)
                INIT_DRAW, DRAW: begin
                    if (stop) stop_pend <= 1'b1;
                    if (!draw_req) begin
                        draw_req   <= 1'b1;
                        draw_erase <= COLOUR_BLOCK;
                        draw_x     <= x_pos;
                    end else if (draw_ack) begin
                        draw_req <= 1'b0;
                        if (stop_pend || stop) begin
                            state   <= STOPPED;
                            stopped <= 1'b1;
                        end else begin
                            state <= WAIT_TICK;
                        end
                    end
                end
                ERASE: begin
                    if (stop) stop_pend <= 1'b1;
                    if (!draw_req) begin
                        draw_req   <= 1'b1;
                        draw_erase <= COLOUR_BG;
                        draw_x     <= x_pos;
                    end else if (draw_ack) begin
                        // New position is committed as soon as the old one is gone.
                        draw_req     <= 1'b0;
                        x_pos        <= next_x;
                        moving_right <= next_dir;
                        state        <= DRAW;
                    end
                end
                WAIT_TICK: begin
                    if (stop) begin
                        state     <= STOPPED;
                        stopped   <= 1'b1;
                        frame_cnt <= '0;
                    end else if (enable && frame_tick) begin
                        if (frame_cnt == LAST_FRAME) begin
                            frame_cnt <= '0;
                            state     <= ERASE;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                STOPPED: begin
                    stopped <= 1'b1;
                end
                default: begin
                    state <= INIT_DRAW;
                end
            endcase
        end
    end

`ifdef BLOCK_MOTION_OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overrun_cnt <= 8'd0;
            overrun     <= 1'b0;
        end else if (frame_tick && busy && enable) begin
            if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
            overrun <= 1'b1;
        end
    end
`endif

endmodule
